// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash reader: issues a 0x03 READ of `len` bytes starting at
// `addr` and streams the returned bytes out on a valid/ready byte port.
// SCK is generated by a CLKDIV-cycle half-period divider that freezes
// (SCK held low) whenever an assembled byte cannot yet be handed out.
module spi_flash_reader #(
  parameter int CLKDIV = 2,
  parameter int W_LEN  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [W_LEN-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic             spi_sck,
  output logic             spi_csn,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_CMDADDR,
    S_DATA,
    S_DESEL,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    div_cnt;
  logic [31:0]      tx_sr;
  logic [4:0]       cmd_cnt;
  logic [2:0]       bit_cnt;
  logic [W_LEN-1:0] len_cnt;
  logic [7:0]       rx_sr;
  logic [7:0]       pend_byte;
  logic             pend;
  logic             div_end;
  logic [7:0]       rx_byte;

  assign div_end = (div_cnt == CNT_MAX);
  // Byte completed by the MISO bit sampled on the current SCK fall.
  assign rx_byte = {rx_sr[6:0], spi_miso};

  // Transaction FSM, SCK divider, shift registers and output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      spi_sck     <= 1'b0;
      spi_csn     <= 1'b1;
      spi_mosi    <= 1'b0;
      pend        <= 1'b0;
      div_cnt     <= '0;
    end else begin
      done <= 1'b0;

      // Consumer handshake, then move a stalled byte into the output slot.
      if (rdata_valid && rdata_ready) rdata_valid <= 1'b0;
      if (pend && (!rdata_valid || rdata_ready)) begin
        rdata       <= pend_byte;
        rdata_valid <= 1'b1;
        pend        <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          // busy is still 1 for the cycle right after DONE, so that
          // cycle's start is ignored as well.
          if (start && !busy) begin
            tx_sr   <= {8'h03, addr};
            len_cnt <= len;
            state   <= (len == '0) ? S_DONE : S_SEL;
          end
        end

        S_SEL: begin
          busy     <= 1'b1;
          spi_csn  <= 1'b0;
          spi_mosi <= tx_sr[31];
          div_cnt  <= '0;
          cmd_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= S_CMDADDR;
        end

        S_CMDADDR, S_DATA: begin
          if (spi_sck) begin
            // High phase: the falling edge is the MISO sampling point and
            // the only place MOSI advances (zeros shift in after the address).
            if (div_end) begin
              div_cnt  <= '0;
              spi_sck  <= 1'b0;
              tx_sr    <= {tx_sr[30:0], 1'b0};
              spi_mosi <= tx_sr[30];
              if (state == S_CMDADDR) begin
                cmd_cnt <= cmd_cnt + 1'b1;
                if (cmd_cnt == 5'd31) state <= S_DATA;
              end else begin
                rx_sr   <= rx_byte;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) begin
                  len_cnt <= len_cnt - 1'b1;
                  if (!rdata_valid || rdata_ready) begin
                    rdata       <= rx_byte;
                    rdata_valid <= 1'b1;
                  end else begin
                    pend_byte <= rx_byte;
                    pend      <= 1'b1;
                  end
                end
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else begin
            // Low phase: frozen while a byte waits, so the next rise comes
            // a full half-period after the byte is handed over.
            if (pend) begin
              div_cnt <= '0;
            end else if (div_end) begin
              div_cnt <= '0;
              if (state == S_DATA && len_cnt == '0) begin
                spi_csn <= 1'b1;
                state   <= S_DESEL;
              end else begin
                spi_sck <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end

        S_DESEL: begin
          // CSn high time before the completion pulse.
          if (div_end) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // Zero-length request: a single busy cycle with the done pulse.
          done  <= 1'b1;
          busy  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: three instances (CLKDIV 2, 1, 5)
// each talking to a behavioural mode-0 flash model driven from the bench.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        start [3];
  logic        ready [3];
  logic        busy [3];
  logic        done [3];
  logic [7:0]  rdata [3];
  logic        valid [3];
  logic        sck [3];
  logic        csn [3];
  logic        mosi [3];
  logic        miso [3];

  int checks = 0;
  int errors = 0;

  // Flash model / monitor state, all owned by the negedge process below.
  int          fcnt [3];
  logic [31:0] fcmd [3];
  logic [23:0] faddr [3];
  logic [7:0]  fsh [3];
  int          fbp [3];
  int          last_frame [3];
  int          csn_falls [3];
  int          mosi_bad [3];
  int          ndone [3];
  int          ngot [3];
  logic [7:0]  got [3][64];
  int          run [3];
  int          hi_min [3], hi_max [3], lo_min [3], lo_max [3];
  logic        sck_prev [3];
  logic        csn_prev [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_flash_reader #(
      .CLKDIV((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
      .W_LEN (16)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .addr       (addr),
      .len        (len),
      .busy       (busy[g]),
      .done       (done[g]),
      .rdata      (rdata[g]),
      .rdata_valid(valid[g]),
      .rdata_ready(ready[g]),
      .spi_sck    (sck[g]),
      .spi_csn    (csn[g]),
      .spi_mosi   (mosi[g]),
      .spi_miso   (miso[g])
    );
  end

  function automatic logic [7:0] fmem(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hA5;
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'hFFFFFF: return 8'h5C;
      24'h000000: return 8'hC3;
      default:    return a[7:0] ^ 8'h6B;
    endcase
  endfunction

  initial begin
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0; ready[g] = 1'b0; miso[g] = 1'b0;
      fcnt[g] = 0; fcmd[g] = '0; faddr[g] = '0; fsh[g] = '0; fbp[g] = 0;
      last_frame[g] = 0; csn_falls[g] = 0; mosi_bad[g] = 0; ndone[g] = 0;
      ngot[g] = 0; run[g] = 0; hi_min[g] = 1000; hi_max[g] = 0;
      lo_min[g] = 1000; lo_max[g] = 0; sck_prev[g] = 1'b0; csn_prev[g] = 1'b1;
    end
  end

  // Flash model, byte collector and SCK run-length monitor. SCK only moves
  // on posedge clk, so edges are detected here half a cycle later; MISO
  // therefore changes after the DUT has sampled on that falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (valid[g] && ready[g] && ngot[g] < 64) begin
        got[g][ngot[g]] = rdata[g];
        ngot[g]++;
      end
      if (done[g]) ndone[g]++;
      if (csn[g]) begin
        if (!csn_prev[g]) last_frame[g] = fcnt[g];
        fcnt[g] = 0;
        run[g]  = 0;
      end else begin
        if (csn_prev[g]) csn_falls[g]++;
        if (sck[g] && !sck_prev[g]) begin
          if (fcnt[g] < 32) fcmd[g] = {fcmd[g][30:0], mosi[g]};
          else if (mosi[g]) mosi_bad[g]++;
          fcnt[g]++;
        end
        if (!sck[g] && sck_prev[g] && fcnt[g] >= 32) begin
          if (fcnt[g] == 32 || fbp[g] == 8) begin
            faddr[g] = (fcnt[g] == 32) ? fcmd[g][23:0] : faddr[g] + 24'd1;
            fsh[g]   = fmem(faddr[g]);
            fbp[g]   = 0;
          end
          miso[g] = fsh[g][7];
          fsh[g]  = {fsh[g][6:0], 1'b0};
          fbp[g]++;
        end
        if (run[g] == 0) begin
          run[g] = 1;
        end else if (sck[g] == sck_prev[g]) begin
          run[g]++;
        end else begin
          if (sck_prev[g]) begin
            if (run[g] < hi_min[g]) hi_min[g] = run[g];
            if (run[g] > hi_max[g]) hi_max[g] = run[g];
          end else begin
            if (run[g] < lo_min[g]) lo_min[g] = run[g];
            if (run[g] > lo_max[g]) lo_max[g] = run[g];
          end
          run[g] = 1;
        end
      end
      sck_prev[g] = sck[g];
      csn_prev[g] = csn[g];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    int n;
    n = 0;
    while (!done[g] && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, done[g]}, 32'd1);
  endtask

  task automatic kick(input int g, input logic [23:0] a, input logic [15:0] l);
    addr = a;
    len = l;
    start[g] = 1'b1;
    tick(1);
    start[g] = 1'b0;
  endtask

  task automatic sweep(input int g, input int d);
    int base, falls0, dn0;
    base = ngot[g];
    falls0 = csn_falls[g];
    ready[g] = 1'b1;
    kick(g, 24'hFFFFFF, 16'd2);
    tick(3);
    chk("sweep_busy", {31'd0, busy[g]}, 32'd1);
    kick(g, 24'h000010, 16'd1);
    dn0 = ndone[g];
    wait_done(g, 3000, "sweep_done");
    tick(20);
    chk("sweep_count", ngot[g] - base, 32'd2);
    chk("sweep_b0", {24'd0, got[g][base]}, 32'h5C);
    chk("sweep_b1", {24'd0, got[g][base+1]}, 32'hC3);
    chk("sweep_one_frame", csn_falls[g] - falls0, 32'd1);
    chk("sweep_one_done", ndone[g] - dn0, 32'd1);
    chk("sweep_hi_min", hi_min[g], d);
    chk("sweep_hi_max", hi_max[g], d);
    chk("sweep_lo_min", lo_min[g], d);
    chk("sweep_lo_max", lo_max[g], d);
  endtask

  initial begin
    int base, falls0, dn0, n, hi_seen;

    // Reset values
    tick(3);
    for (int g = 0; g < 3; g++)
      chk("reset_state", {20'd0, busy[g], done[g], rdata[g], valid[g], sck[g], csn[g], mosi[g]},
          {20'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;
    tick(2);

    // Basic read, CLKDIV=2, consumer not ready
    base = ngot[0];
    kick(0, 24'h000010, 16'd1);                 // edge t
    chk("sel_busy_low", {31'd0, busy[0]}, 32'd0);
    tick(1);                                    // t+1
    chk("frame_start", {29'd0, busy[0], csn[0], mosi[0]}, {29'd0, 3'b100});
    tick(1);                                    // t+2
    chk("sck_low_t2", {31'd0, sck[0]}, 32'd0);
    tick(1);                                    // t+3
    chk("sck_rise_t3", {31'd0, sck[0]}, 32'd1);
    tick(157);                                  // t+160
    chk("byte_not_yet", {31'd0, valid[0]}, 32'd0);
    tick(1);                                    // t+161
    chk("byte_valid", {23'd0, valid[0], rdata[0]}, {23'd0, 1'b1, 8'hA5});
    chk("csn_still_low", {31'd0, csn[0]}, 32'd0);
    tick(2);                                    // t+163
    chk("csn_rise", {30'd0, csn[0], done[0]}, {30'd0, 2'b10});
    tick(2);                                    // t+165
    chk("done_pulse", {30'd0, done[0], busy[0]}, {30'd0, 2'b11});
    tick(1);
    chk("after_done", {30'd0, done[0], busy[0]}, 32'd0);
    chk("basic_pulses", last_frame[0], 32'd40);
    chk("basic_mosi", fcmd[0], 32'h03000010);
    chk("basic_rdata_hold", {23'd0, valid[0], rdata[0]}, {23'd0, 1'b1, 8'hA5});
    ready[0] = 1'b1;
    tick(1);
    chk("basic_handshake", {31'd0, valid[0]}, 32'd0);
    chk("basic_collected", {24'd0, got[0][base]}, 32'hA5);

    // Burst read, ready tied high
    base = ngot[0];
    falls0 = csn_falls[0];
    kick(0, 24'h000100, 16'd4);
    wait_done(0, 2000, "burst_done");
    tick(3);
    chk("burst_count", ngot[0] - base, 32'd4);
    for (int i = 0; i < 4; i++)
      chk("burst_byte", {24'd0, got[0][base+i]}, {24'd0, fmem(24'h000100 + 24'(i))});
    chk("burst_pulses", last_frame[0], 32'd64);
    chk("burst_frames", csn_falls[0] - falls0, 32'd1);
    chk("burst_mosi_data", mosi_bad[0], 32'd0);

    // Backpressure: consumer stalls 50 cycles once byte 0 is out
    base = ngot[0];
    ready[0] = 1'b0;
    kick(0, 24'h000100, 16'd4);
    n = 0;
    while (!valid[0] && n < 500) begin
      tick(1);
      n++;
    end
    chk("bp_first_valid", {31'd0, valid[0]}, 32'd1);
    hi_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i >= 40 && sck[0]) hi_seen++;
    end
    chk("bp_sck_held", hi_seen, 32'd0);
    chk("bp_rdata_hold", {23'd0, valid[0], rdata[0]}, {23'd0, 1'b1, 8'h11});
    ready[0] = 1'b1;
    wait_done(0, 2000, "bp_done");
    tick(3);
    chk("bp_count", ngot[0] - base, 32'd4);
    for (int i = 0; i < 4; i++)
      chk("bp_byte", {24'd0, got[0][base+i]}, {24'd0, fmem(24'h000100 + 24'(i))});
    chk("bp_pulses", last_frame[0], 32'd64);

    // Zero-length request
    falls0 = csn_falls[0];
    n = fcnt[0];
    kick(0, 24'h000010, 16'd0);
    tick(1);
    chk("len0_done", {29'd0, done[0], busy[0], csn[0]}, {29'd0, 3'b111});
    tick(1);
    chk("len0_after", {30'd0, done[0], busy[0]}, 32'd0);
    tick(5);
    chk("len0_no_frame", csn_falls[0] - falls0, 32'd0);

    // Reset abort during address bit 10 (pulse 22) of a len=8 read
    dn0 = ndone[0];
    kick(0, 24'h000200, 16'd8);
    n = 0;
    while (fcnt[0] < 22 && n < 500) begin
      tick(1);
      n++;
    end
    chk("abort_reached", fcnt[0], 32'd22);
    rst = 1'b1;
    tick(1);
    chk("abort_state", {28'd0, csn[0], sck[0], busy[0], done[0]}, {28'd0, 4'b1000});
    rst = 1'b0;
    tick(3);
    chk("abort_no_done", ndone[0] - dn0, 32'd0);
    base = ngot[0];
    kick(0, 24'h000010, 16'd1);
    wait_done(0, 1000, "abort_retry_done");
    tick(2);
    chk("abort_retry_count", ngot[0] - base, 32'd1);
    chk("abort_retry_byte", {24'd0, got[0][base]}, 32'hA5);

    // Divider sweep with wrap at the top of the address space
    sweep(1, 1);
    sweep(2, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
